// File: rtl/comp_vacc_rd_sched_pkg.sv
// Shared definitions for the comp_vacc readout scheduler.
//
// Contents:
//   sel_width()        antenna-select width. It is never less than 1, so a
//                      single-antenna build still has real ports.
//   num_pairs()        number of antenna pairs walked per frame.
//   START_DLY          cycles from the window wrap to the first read address.
//   RD_LAT             read latency of comp_vacc: BRAM read 1 + output register 1.
//   AUTOS_EN           1 when COMP_VACC_RD_SCHED_AUTOS_EN is defined.
//                      Autocorrelations (a==b) are then read as well.
//   sched_state_e      scheduler FSM states.
//
// Configuration macro: COMP_VACC_RD_SCHED_AUTOS_EN
//   Defined   : pairs with b >= a are read (autocorrelations included).
//   Undefined : pairs with b >  a are read (cross products only).
package comp_vacc_rd_sched_pkg;

    localparam int START_DLY = 4;
    localparam int RD_LAT    = 2;

`ifdef COMP_VACC_RD_SCHED_AUTOS_EN
    localparam bit AUTOS_EN = 1'b1;
`else
    localparam bit AUTOS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT,
        ST_READ
    } sched_state_e;

    function automatic int sel_width(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int num_pairs(input int n, input bit autos);
        return autos ? (n * (n + 1)) / 2 : (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/comp_vacc_rd_sched_pair_gen.sv
// Triangular antenna-pair walker.
//
// A start pulse loads the first pair, and busy goes high on the following
// cycle. One pair is presented per cycle, in this order:
//   a = 0 .. N-1
//   b = a .. N-1      when AUTOS = 1
//   b = a+1 .. N-1    when AUTOS = 0
// The walker stops by itself after the last pair. The a/b registers then
// hold their final value. They drive comp_vacc ant_sel directly.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a new walk (ignored while abort is high)
//   abort           stop walking immediately
//   busy            the current ant_a/ant_b value is a pair to be read
//   first           busy and this is the first pair of the walk
//   last            busy and this is the last pair of the walk
//   ant_a, ant_b    current pair
module comp_vacc_rd_sched_pair_gen #(
    parameter int N     = 32,
    parameter int VLB   = 5,
    parameter bit AUTOS = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           first,
    output logic           last,
    output logic [VLB-1:0] ant_a,
    output logic [VLB-1:0] ant_b
);

    localparam int LAST_A_I = AUTOS ? N - 1 : ((N > 1) ? N - 2 : 0);
    localparam logic [VLB-1:0] LAST_A = VLB'(LAST_A_I);
    localparam logic [VLB-1:0] LAST_B = VLB'(N - 1);
    // The first b of each row sits this far past a.
    localparam logic [VLB-1:0] B_OFF  = VLB'(AUTOS ? 0 : 1);

    logic           busy_reg;
    logic           first_reg;
    logic [VLB-1:0] a_reg;
    logic [VLB-1:0] b_reg;

    assign busy  = busy_reg;
    assign first = busy_reg & first_reg;
    assign last  = busy_reg && (a_reg == LAST_A) && (b_reg == LAST_B);
    assign ant_a = a_reg;
    assign ant_b = b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg  <= 1'b0;
            first_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else if (abort) begin
            busy_reg  <= 1'b0;
            first_reg <= 1'b0;
        end else if (start) begin
            busy_reg  <= 1'b1;
            first_reg <= 1'b1;
            a_reg     <= '0;
            b_reg     <= B_OFF;
        end else if (busy_reg) begin
            first_reg <= 1'b0;
            if (last) begin
                busy_reg <= 1'b0;
            end else if (b_reg == LAST_B) begin
                a_reg <= a_reg + VLB'(1);
                b_reg <= a_reg + VLB'(1) + B_OFF;
            end else begin
                b_reg <= b_reg + VLB'(1);
            end
        end
    end

endmodule

// File: rtl/comp_vacc_rd_sched.sv
// Readout sequencer for one comp_vacc double-buffered accumulator.
//
// What it does:
//   - Issues the comp_vacc sync.
//   - Keeps a local copy of the comp_vacc write window and active buffer.
//   - After every buffer swap, walks all antenna pairs over the completed
//     buffer.
//   - Emits pair-tagged strobes. These line up with comp_vacc dout_a/dout_b.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   sync_in             upstream sync pulse; restarts accumulation
//   vacc_sync           to comp_vacc sync. This is sync_in delayed one cycle,
//                       and it is held high during reset.
//   ant_sel_a/_b        to comp_vacc ant_sel_a/_b. The last value is held
//                       outside readout.
//   buf_sel             to comp_vacc buf_sel; the buffer being read
//   pair_vld            comp_vacc dout_a/dout_b are valid this cycle
//   pair_a/pair_b       antenna pair of the current valid output
//   frame_first/_last   first / last pair of the frame (only with pair_vld)
//   frame_cnt           frames fully published since reset (wraps)
//   abort_err           sticky; a readout was cut short by a sync
//
// Configuration macro: COMP_VACC_RD_SCHED_AUTOS_EN (see the package).
module comp_vacc_rd_sched
    import comp_vacc_rd_sched_pkg::*;
#(
    parameter int ACC_LEN_BITS   = 8,
    parameter int VECTOR_LENGTH  = 32,
    parameter int FRAME_CNT_BITS = 16,
    localparam int VLB = sel_width(VECTOR_LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sync_in,
    output logic                      vacc_sync,
    output logic [VLB-1:0]            ant_sel_a,
    output logic [VLB-1:0]            ant_sel_b,
    output logic                      buf_sel,
    output logic                      pair_vld,
    output logic [VLB-1:0]            pair_a,
    output logic [VLB-1:0]            pair_b,
    output logic                      frame_first,
    output logic                      frame_last,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt,
    output logic                      abort_err
);

    localparam int WIN_BITS = ACC_LEN_BITS + VLB;
    localparam int W        = (1 << ACC_LEN_BITS) * VECTOR_LENGTH;
    localparam int P        = num_pairs(VECTOR_LENGTH, AUTOS_EN);
    localparam logic [WIN_BITS-1:0] WIN_LAST = WIN_BITS'(W - 1);
    // The walker start is issued one cycle before the first address is
    // wanted. With START_DLY = 4, the first address then appears four cycles
    // after the wrap cycle.
    localparam logic [2:0] DLY_LAST = 3'(START_DLY - 2);

    // A readout must finish before the next wrap. Otherwise it would read
    // a buffer that is already being overwritten.
    if (START_DLY + P > W) begin : g_len_check
        $error("comp_vacc_rd_sched: START_DLY + pairs exceeds accumulation window");
    end

    // ------------------------------------------------------------------
    // Write-window mirror of comp_vacc: comp_ctr and active_ram
    // ------------------------------------------------------------------
    logic                vacc_sync_reg;
    logic [WIN_BITS-1:0] win_ctr_reg;
    logic                wr_buf_reg;
    logic                done_buf_reg;
    logic                wrap;

    assign wrap = !vacc_sync_reg && (win_ctr_reg == WIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            vacc_sync_reg <= 1'b1;
            win_ctr_reg   <= '0;
            wr_buf_reg    <= 1'b0;
            done_buf_reg  <= 1'b0;
        end else begin
            vacc_sync_reg <= sync_in;
            if (vacc_sync_reg) begin
                win_ctr_reg <= '0;
                wr_buf_reg  <= 1'b0;
            end else if (wrap) begin
                win_ctr_reg  <= '0;
                wr_buf_reg   <= ~wr_buf_reg;
                done_buf_reg <= wr_buf_reg;
            end else begin
                win_ctr_reg <= win_ctr_reg + WIN_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pair walker
    // ------------------------------------------------------------------
    logic           pg_start;
    logic           pg_abort;
    logic           pg_busy;
    logic           pg_first;
    logic           pg_last;
    logic [VLB-1:0] pg_a;
    logic [VLB-1:0] pg_b;

    comp_vacc_rd_sched_pair_gen #(
        .N     (VECTOR_LENGTH),
        .VLB   (VLB),
        .AUTOS (AUTOS_EN)
    ) u_pair_gen (
        .clk   (clk),
        .rst   (rst),
        .start (pg_start),
        .abort (pg_abort),
        .busy  (pg_busy),
        .first (pg_first),
        .last  (pg_last),
        .ant_a (pg_a),
        .ant_b (pg_b)
    );

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    sched_state_e              state_reg;
    sched_state_e              state_next;
    logic [2:0]                dly_ctr_reg;
    logic                      abort_err_reg;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_reg;
    // Set for a frame that has no pairs. This happens only for a
    // cross-only build with one antenna.
    logic                      empty_frame;

    always_comb begin
        state_next  = state_reg;
        pg_start    = 1'b0;
        pg_abort    = 1'b0;
        empty_frame = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (vacc_sync_reg) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (wrap) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (vacc_sync_reg) begin
                    pg_abort   = 1'b1;
                    state_next = ST_FILL;
                end else if (dly_ctr_reg == DLY_LAST) begin
                    if (P == 0) begin
                        empty_frame = 1'b1;
                        state_next  = ST_FILL;
                    end else begin
                        pg_start   = 1'b1;
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (vacc_sync_reg) begin
                    pg_abort   = 1'b1;
                    state_next = ST_FILL;
                end else if (pg_last) begin
                    state_next = ST_FILL;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            dly_ctr_reg   <= '0;
            abort_err_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            dly_ctr_reg <= (state_reg == ST_WAIT) ? dly_ctr_reg + 3'd1 : 3'd0;
            if (pg_abort) begin
                abort_err_reg <= 1'b1;
            end
            if ((pair_vld && frame_last) || empty_frame) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output alignment: delay the address-side strobes by RD_LAT
    // ------------------------------------------------------------------
    // An abort masks the address-side strobe in the same cycle. Strobes
    // already in flight still emerge. The last pair of an aborted frame is
    // never issued, so frame_last cannot appear for that frame.
    logic addr_vld;
    assign addr_vld = pg_busy & ~pg_abort;

    logic           vld_pipe   [RD_LAT];
    logic           first_pipe [RD_LAT];
    logic           last_pipe  [RD_LAT];
    logic [VLB-1:0] a_pipe     [RD_LAT];
    logic [VLB-1:0] b_pipe     [RD_LAT];

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe[gi]   <= 1'b0;
                    first_pipe[gi] <= 1'b0;
                    last_pipe[gi]  <= 1'b0;
                    a_pipe[gi]     <= '0;
                    b_pipe[gi]     <= '0;
                end else begin
                    vld_pipe[gi]   <= addr_vld;
                    first_pipe[gi] <= addr_vld & pg_first;
                    last_pipe[gi]  <= addr_vld & pg_last;
                    a_pipe[gi]     <= pg_a;
                    b_pipe[gi]     <= pg_b;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe[gi]   <= 1'b0;
                    first_pipe[gi] <= 1'b0;
                    last_pipe[gi]  <= 1'b0;
                    a_pipe[gi]     <= '0;
                    b_pipe[gi]     <= '0;
                end else begin
                    vld_pipe[gi]   <= vld_pipe[gi-1];
                    first_pipe[gi] <= first_pipe[gi-1];
                    last_pipe[gi]  <= last_pipe[gi-1];
                    a_pipe[gi]     <= a_pipe[gi-1];
                    b_pipe[gi]     <= b_pipe[gi-1];
                end
            end
        end
    end

    assign vacc_sync   = vacc_sync_reg;
    assign ant_sel_a   = pg_a;
    assign ant_sel_b   = pg_b;
    assign buf_sel     = done_buf_reg;
    assign pair_vld    = vld_pipe[RD_LAT-1];
    assign pair_a      = a_pipe[RD_LAT-1];
    assign pair_b      = b_pipe[RD_LAT-1];
    assign frame_first = first_pipe[RD_LAT-1];
    assign frame_last  = last_pipe[RD_LAT-1];
    assign frame_cnt   = frame_cnt_reg;
    assign abort_err   = abort_err_reg;

endmodule
